l2_flush_engine: RTL and testbench
==================================

Name: l2_flush_engine

Overview:
Parametrised flush/writeback sequencer for the Spandex L2. It provides the flush and fence-driven writeback behaviour that the current L2 top level ties off: `ongoing_flush`, `flush_done` and `acc_flush_done` are constant 0 there. The engine walks every set/way of the L2 local memory and issues one writeback per line holding Owned words. Depending on mode, it then invalidates the line or downgrades it to Valid. It sits beside `l2_fsm`, shares the localmem read/write ports under arbitration, and defers to the MSHR on set conflicts.

Parameters:
L2_SETS, 256, number of sets (power of 2, >=2)
L2_WAYS, 16, ways per set (power of 2, >=2)
WORDS_PER_LINE, 4, words per line
WORD_BITS, 64, bits per word
TAG_BITS, 20, tag width; line address = {tag, set}, width TAG_BITS+log2(L2_SETS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush_valid  in  1  flush request
flush_ready  out  1  engine accepts request
flush_all  in  1  mode, sampled at handshake: 1 = write back Owned words and invalidate the line; 0 = write back Owned words and downgrade them to Valid
conflict_stall  in  1  MSHR holds an entry for the current set
mem_rd_en  out  1  localmem read strobe
mem_set  out  log2(L2_SETS)  current set
mem_way  out  log2(L2_WAYS)  current way
mem_rd_tag  in  TAG_BITS  tag, valid one cycle after mem_rd_en
mem_rd_state  in  2*WORDS_PER_LINE  per-word state (I=0, V=1, O=2, S=3), same timing as mem_rd_tag
mem_rd_line  in  WORDS_PER_LINE*WORD_BITS  line data, same timing as mem_rd_tag
mem_wr_en  out  1  state write strobe
mem_wr_state  out  2*WORDS_PER_LINE  new per-word states
wb_valid  out  1  writeback request
wb_ready  in  1  writeback accepted
wb_addr  out  TAG_BITS+log2(L2_SETS)  line address
wb_word_mask  out  WORDS_PER_LINE  Owned words being written back
wb_line  out  WORDS_PER_LINE*WORD_BITS  line data
busy  out  1  flush in progress
flush_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0): FSM returns to IDLE, set/way counters cleared, captured mode and wb registers cleared. All outputs 0 except flush_ready=1.
- Reset mid-operation aborts the walk immediately: no flush_done pulse, no further writes.
- FSM states: IDLE, READ, EVAL, WB, WRITE, NEXT, DONE.
- IDLE:
  - flush_ready=1, busy=0.
  - On flush_valid&&flush_ready: latch flush_all, set=0, way=0, go to READ.
- Any state other than IDLE: flush_ready=0 and busy=1; flush_valid is ignored.
- READ:
  - If conflict_stall=1, stay in READ with mem_rd_en=0.
  - Otherwise mem_rd_en=1 for one cycle, go to EVAL.
- EVAL (read data valid this cycle):
  - owned = per-word mask of state==O.
  - If owned!=0: register wb_addr={mem_rd_tag,set}, wb_word_mask=owned, wb_line=mem_rd_line, and the new state vector; go to WB.
  - Else if flush_all=1 and any word!=I: register the all-I state vector; go to WRITE.
  - Else go to NEXT.
- WB:
  - wb_valid=1; wb_addr, wb_word_mask and wb_line are held stable until wb_ready.
  - On wb_valid&&wb_ready, go to WRITE.
  - wb_valid is never withdrawn before the handshake.
- WRITE:
  - mem_wr_en=1 for exactly one cycle at the current set/way, then go to NEXT.
  - mem_wr_state: flush_all=1 gives all words I; flush_all=0 sets Owned words to V and leaves other words unchanged.
- NEXT:
  - If way==L2_WAYS-1 and set==L2_SETS-1, go to DONE.
  - Else if way==L2_WAYS-1: way=0, set=set+1, go to READ.
  - Else way=way+1, go to READ.
  - Counters never wrap past the last set.
- DONE: flush_done=1 for one cycle, then IDLE.
- Latency: for a cache with no Owned words (and, for flush_all=1, all lines I) and no stalls, flush_done asserts 3*L2_SETS*L2_WAYS+1 cycles after the handshake cycle. Each Owned line adds 2 cycles plus the wb_ready wait.
- A Shared-only or Valid-only line in mode 0 causes no write and no writeback.
- mem_set/mem_way are combinational from the counters and are valid in READ, EVAL and WRITE.

Test Plan:
- L2_SETS=4, L2_WAYS=2, empty cache, flush_all=0, wb_ready=1 -> no wb_valid, no mem_wr_en; flush_done pulses exactly 25 cycles after the handshake; flush_ready returns to 1 the next cycle.
- Set 2 way 1 tag 0x5 with states {O,V,O,I}, flush_all=0 -> one writeback with wb_addr=0x16, wb_word_mask=4'b0101 and correct line; mem_wr_state={V,V,V,I}.
- Same line, flush_all=1, wb_ready held low 10 cycles -> wb fields stable for all 11 cycles; mem_wr_state all I; set 0 way 0 at {V,V,V,V} written all-I with no writeback.
- conflict_stall held high 5 cycles while at set 1 -> mem_rd_en stays 0 for those cycles; total completion time extended by exactly 5 cycles.
- flush_valid reasserted mid-walk -> flush_ready=0 and the second request is not accepted until after flush_done.
- rst asserted in WB state -> wb_valid drops asynchronously, no flush_done; a new flush after reset starts from set 0 way 0.

Source files
------------

// File: rtl/l2_flush_engine.sv
// Flush/writeback sequencer for the Spandex L2: walks every set/way, writes back
// Owned words, then invalidates (flush_all=1) or downgrades them to Valid (flush_all=0).
module l2_flush_engine #(
  parameter int L2_SETS        = 256,
  parameter int L2_WAYS        = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int TAG_BITS       = 20,
  localparam int SET_W  = $clog2(L2_SETS),
  localparam int WAY_W  = $clog2(L2_WAYS),
  localparam int ADDR_W = TAG_BITS + SET_W,
  localparam int LINE_W = WORDS_PER_LINE * WORD_BITS,
  localparam int ST_W   = 2 * WORDS_PER_LINE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_valid,
  output logic                      flush_ready,
  input  logic                      flush_all,
  input  logic                      conflict_stall,
  output logic                      mem_rd_en,
  output logic [SET_W-1:0]          mem_set,
  output logic [WAY_W-1:0]          mem_way,
  input  logic [TAG_BITS-1:0]       mem_rd_tag,
  input  logic [ST_W-1:0]           mem_rd_state,
  input  logic [LINE_W-1:0]         mem_rd_line,
  output logic                      mem_wr_en,
  output logic [ST_W-1:0]           mem_wr_state,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [WORDS_PER_LINE-1:0] wb_word_mask,
  output logic [LINE_W-1:0]         wb_line,
  output logic                      busy,
  output logic                      flush_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EVAL  = 3'd2,
    WB    = 3'd3,
    WRITE = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(L2_SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(L2_WAYS - 1);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_V = 2'd1;
  localparam logic [1:0] ST_O = 2'd2;

  state_t                    state_reg;
  state_t                    state_next;
  logic [SET_W-1:0]          set_reg;
  logic [WAY_W-1:0]          way_reg;
  logic                      flush_all_reg;
  logic [ADDR_W-1:0]         wb_addr_reg;
  logic [WORDS_PER_LINE-1:0] wb_mask_reg;
  logic [LINE_W-1:0]         wb_line_reg;
  logic [ST_W-1:0]           wr_state_reg;

  logic [WORDS_PER_LINE-1:0] owned;
  logic [WORDS_PER_LINE-1:0] present;
  logic [ST_W-1:0]           downgraded;
  logic [ST_W-1:0]           new_state;
  logic                      last_way;
  logic                      last_set;

  // Per-word decode of the line just read: Owned words become V in downgrade mode.
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign owned[gi]            = (mem_rd_state[2*gi +: 2] == ST_O);
      assign present[gi]          = (mem_rd_state[2*gi +: 2] != ST_I);
      assign downgraded[2*gi +: 2] = owned[gi] ? ST_V : mem_rd_state[2*gi +: 2];
    end
  endgenerate

  assign new_state = flush_all_reg ? '0 : downgraded;
  assign last_way  = (way_reg == LAST_WAY);
  assign last_set  = (set_reg == LAST_SET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    flush_ready = 1'b0;
    busy        = 1'b1;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    wb_valid    = 1'b0;
    flush_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        flush_ready = 1'b1;
        busy        = 1'b0;
        if (flush_valid) begin
          state_next = READ;
        end
      end
      READ: begin
        // The MSHR owns this set while it stalls us; hold off the read.
        if (!conflict_stall) begin
          mem_rd_en  = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (owned != '0) begin
          state_next = WB;
        end else if (flush_all_reg && (present != '0)) begin
          state_next = WRITE;
        end else begin
          state_next = NEXT;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_wr_en  = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        if (last_way && last_set) begin
          state_next = DONE;
        end else begin
          state_next = READ;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_reg       <= '0;
      way_reg       <= '0;
      flush_all_reg <= 1'b0;
      wb_addr_reg   <= '0;
      wb_mask_reg   <= '0;
      wb_line_reg   <= '0;
      wr_state_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_valid) begin
            flush_all_reg <= flush_all;
            set_reg       <= '0;
            way_reg       <= '0;
          end
        end
        EVAL: begin
          if (owned != '0) begin
            wb_addr_reg  <= {mem_rd_tag, set_reg};
            wb_mask_reg  <= owned;
            wb_line_reg  <= mem_rd_line;
            wr_state_reg <= new_state;
          end else if (flush_all_reg && (present != '0)) begin
            wr_state_reg <= '0;
          end
        end
        NEXT: begin
          // Counters park on the final set/way instead of wrapping.
          if (last_way) begin
            if (!last_set) begin
              way_reg <= '0;
              set_reg <= set_reg + 1'b1;
            end
          end else begin
            way_reg <= way_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_set      = set_reg;
  assign mem_way      = way_reg;
  assign mem_wr_state = wr_state_reg;
  assign wb_addr      = wb_addr_reg;
  assign wb_word_mask = wb_mask_reg;
  assign wb_line      = wb_line_reg;

endmodule

// File: tb/tb_l2_flush_engine.sv
// Scoreboard bench for l2_flush_engine on a 4-set x 2-way cache with a behavioural localmem.
module tb_l2_flush_engine;

  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int WORDS = 4;
  localparam int WBITS = 16;
  localparam int TBITS = 8;
  localparam int LINES = SETS * WAYS;
  localparam int BASE_LAT = 3 * LINES + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_valid = 1'b0;
  logic        flush_ready;
  logic        flush_all = 1'b0;
  logic        conflict_stall = 1'b0;
  logic        mem_rd_en;
  logic [1:0]  mem_set;
  logic        mem_way;
  logic [7:0]  mem_rd_tag;
  logic [7:0]  mem_rd_state;
  logic [63:0] mem_rd_line;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_state;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [9:0]  wb_addr;
  logic [3:0]  wb_word_mask;
  logic [63:0] wb_line;
  logic        busy;
  logic        flush_done;

  l2_flush_engine #(
    .L2_SETS(SETS), .L2_WAYS(WAYS), .WORDS_PER_LINE(WORDS), .WORD_BITS(WBITS), .TAG_BITS(TBITS)
  ) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_all(flush_all), .conflict_stall(conflict_stall), .mem_rd_en(mem_rd_en),
    .mem_set(mem_set), .mem_way(mem_way), .mem_rd_tag(mem_rd_tag),
    .mem_rd_state(mem_rd_state), .mem_rd_line(mem_rd_line), .mem_wr_en(mem_wr_en),
    .mem_wr_state(mem_wr_state), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_word_mask(wb_word_mask), .wb_line(wb_line),
    .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [63:0] line;
  } wb_t;

  typedef struct {
    logic [1:0] set;
    logic       way;
    logic [7:0] st;
  } wr_t;

  wb_t wb_q[$];
  wr_t wr_q[$];
  int  done_q[$];

  // Behavioural localmem: one-cycle read latency, preload port for the stimulus.
  logic [7:0]  tag_mem [LINES];
  logic [7:0]  st_mem  [LINES];
  logic [63:0] line_mem[LINES];
  logic        ld_clr = 1'b0;
  logic        ld_en  = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [7:0]  ld_tag = '0;
  logic [7:0]  ld_st  = '0;
  logic [63:0] ld_line = '0;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < LINES; i++) begin
        st_mem[i]   <= '0;
        tag_mem[i]  <= '0;
        line_mem[i] <= '0;
      end
    end else if (ld_en) begin
      tag_mem[ld_idx]  <= ld_tag;
      st_mem[ld_idx]   <= ld_st;
      line_mem[ld_idx] <= ld_line;
    end
    if (mem_wr_en) st_mem[{mem_set, mem_way}] <= mem_wr_state;
    if (mem_rd_en) begin
      mem_rd_tag   <= tag_mem[{mem_set, mem_way}];
      mem_rd_state <= st_mem[{mem_set, mem_way}];
      mem_rd_line  <= line_mem[{mem_set, mem_way}];
    end
  end

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Monitor: compares every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (flush_done) begin
      done_cnt++;
      if (done_q.size() == 0) fail_now("done_unexpected");
      else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        fail_now("wb_unexpected");
      end else begin
        check("wb_addr", 64'(wb_addr), 64'(wb_q[0].addr));
        check("wb_mask", 64'(wb_word_mask), 64'(wb_q[0].mask));
        check("wb_line", wb_line, wb_q[0].line);
        if (wb_ready) void'(wb_q.pop_front());
      end
    end
    if (mem_wr_en) begin
      if (wr_q.size() == 0) begin
        fail_now("write_unexpected");
      end else begin
        check("write_loc", 64'({mem_set, mem_way}), 64'({wr_q[0].set, wr_q[0].way}));
        check("write_state", 64'(mem_wr_state), 64'(wr_q[0].st));
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic mem_clear();
    tick(); ld_clr = 1'b1;
    tick(); ld_clr = 1'b0;
  endtask

  task automatic mem_load(input logic [2:0] idx, input logic [7:0] tag, input logic [7:0] st,
                          input logic [63:0] line);
    tick();
    ld_en = 1'b1; ld_idx = idx; ld_tag = tag; ld_st = st; ld_line = line;
    tick();
    ld_en = 1'b0;
  endtask

  int last_h = 0;

  // Handshake in this cycle; the following cycle must be a READ of set 0 way 0.
  task automatic start_flush(input logic mode, input int lat);
    tick();
    check("ready_before_start", 64'(flush_ready), 64'd1);
    last_h = cyc;
    flush_all = mode;
    flush_valid = 1'b1;
    done_q.push_back(cyc + lat);
    tick();
    flush_valid = 1'b0;
    check("first_read", 64'({busy, mem_rd_en, mem_set, mem_way}), 64'b11_00_0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    if (done_cnt < target) fail_now("done_timeout");
  endtask

  task automatic wait_wb();
    int n = 0;
    while (!wb_valid && n < 300) begin
      tick();
      n++;
    end
    if (!wb_valid) fail_now("wb_timeout");
  endtask

  task automatic finish_flush();
    wait_done(done_cnt + 1);
    tick();
    check("ready_after_done", 64'({flush_ready, busy}), 64'b10);
  endtask

  localparam logic [63:0] LINE_A = 64'h1111_2222_3333_4444;

  initial begin
    #100000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem_clear();
    repeat (2) tick();
    check("rst_ready_busy", 64'({flush_ready, busy}), 64'b10);
    check("rst_strobes", 64'({mem_rd_en, mem_wr_en, wb_valid, flush_done}), 64'd0);
    check("rst_wb_regs", 64'({wb_addr, wb_word_mask}), 64'd0);
    rst = 1'b1;

    // 1: empty cache, downgrade mode: no traffic, done after base latency.
    start_flush(1'b0, BASE_LAT);
    finish_flush();

    // 2: set 2 way 1, tag 0x5, {O,V,O,I}: writeback of words 0 and 2, downgrade to {V,V,V,I}.
    mem_load(3'b10_1, 8'h05, 8'h26, LINE_A);
    wb_q.push_back('{addr: 10'h016, mask: 4'b0101, line: LINE_A});
    wr_q.push_back('{set: 2'd2, way: 1'b1, st: 8'h15});
    start_flush(1'b0, BASE_LAT + 2);
    finish_flush();

    // 3: invalidate mode, wb_ready low for 10 cycles; set 0 way 0 all-V gets a plain invalidate.
    mem_load(3'b10_1, 8'h05, 8'h26, LINE_A);
    mem_load(3'b00_0, 8'h33, 8'h55, 64'hDEAD_BEEF_0000_0001);
    wr_q.push_back('{set: 2'd0, way: 1'b0, st: 8'h00});
    wb_q.push_back('{addr: 10'h016, mask: 4'b0101, line: LINE_A});
    wr_q.push_back('{set: 2'd2, way: 1'b1, st: 8'h00});
    wb_ready = 1'b0;
    start_flush(1'b1, BASE_LAT + 1 + 12);
    wait_wb();
    repeat (10) tick();
    wb_ready = 1'b1;
    finish_flush();

    // 4: conflict stall for 5 cycles at set 1.
    mem_clear();
    start_flush(1'b0, BASE_LAT + 5);
    n = 0;
    while (mem_set != 2'd1 && n < 100) begin
      tick();
      n++;
    end
    if (mem_set != 2'd1) fail_now("stall_set_timeout");
    conflict_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_rd_en", 64'(mem_rd_en), 64'd0);
      tick();
    end
    conflict_stall = 1'b0;
    finish_flush();

    // 5: second request raised mid-walk is held off until after flush_done.
    start_flush(1'b0, BASE_LAT);
    repeat (4) tick();
    flush_valid = 1'b1;
    done_q.push_back(last_h + BASE_LAT + 1 + BASE_LAT);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ready_mid_walk", 64'(flush_ready), 64'd0);
      tick();
    end
    wait_done(done_cnt + 1);
    tick();
    check("second_accept_ready", 64'(flush_ready), 64'd1);
    tick();
    flush_valid = 1'b0;
    check("second_accepted_busy", 64'(busy), 64'd1);
    finish_flush();

    // 6: reset while in WB: wb_valid drops at once, no done, restart from set 0 way 0.
    mem_load(3'b10_1, 8'h05, 8'h26, LINE_A);
    wb_q.push_back('{addr: 10'h016, mask: 4'b0101, line: LINE_A});
    wb_ready = 1'b0;
    tick();
    flush_all = 1'b0;
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
    wait_wb();
    rst = 1'b0;
    #1;
    check("rst_async_outputs", 64'({wb_valid, busy, flush_ready}), 64'b001);
    wb_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    wb_ready = 1'b1;
    wb_q.push_back('{addr: 10'h016, mask: 4'b0101, line: LINE_A});
    wr_q.push_back('{set: 2'd2, way: 1'b1, st: 8'h15});
    start_flush(1'b0, BASE_LAT + 2);
    finish_flush();

    check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
